// File: rtl/aclk_pkg.sv
// Shared types and defaults for the aclk timebase generator.
// Holds the fast_mode encoding and default stage moduli.
package aclk_pkg;

  localparam int ACLK_CLK_PER_SEC_DEF  = 256;
  localparam int ACLK_SEC_PER_MIN_DEF  = 60;
  localparam int ACLK_MIN_PER_HOUR_DEF = 60;

  typedef enum logic [1:0] {
    FM_NORMAL    = 2'b00,
    FM_FAST_MIN  = 2'b01,
    FM_FAST_HOUR = 2'b10
  } fast_mode_e;

endpackage

// File: rtl/aclk_mod_counter.sv
// Modulo-N counter stage with synchronous clear and increment.
// terminal flags value == MODULUS-1, independent of inc.
module aclk_mod_counter #(
  parameter  int MODULUS = 2,
  localparam int W       = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         terminal
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign terminal = (value_q == LAST);
  assign value    = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = terminal ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/aclk_timebase_gen.sv
// Second/minute/hour tick generator with fast test modes.
// Hour stage and one_hour built only when ACLK_HOUR_TICK_EN is defined.
module aclk_timebase_gen
  import aclk_pkg::*;
#(
  parameter int CLK_PER_SEC  = ACLK_CLK_PER_SEC_DEF,
  parameter int SEC_PER_MIN  = ACLK_SEC_PER_MIN_DEF,
  parameter int MIN_PER_HOUR = ACLK_MIN_PER_HOUR_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reset_count,
  input  logic                            enable,
  input  logic [1:0]                      fast_mode,
  output logic                            one_second,
  output logic                            one_minute,
  output logic                            one_hour,
  output logic [$clog2(SEC_PER_MIN)-1:0]  sec_cnt,
  output logic [$clog2(MIN_PER_HOUR)-1:0] min_cnt
);

  localparam int PW = $clog2(CLK_PER_SEC);

  logic [PW-1:0] pre_val;
  logic          pre_term;
  logic          sec_term;
  logic          md_min;
  logic          md_hour;
  logic          normal;
  logic          ste;
  logic          sec_inc;
  logic          min_evt;
  logic          min_inc;
  logic          one_second_q, one_second_d;
  logic          one_minute_q, one_minute_d;

  always_comb begin
    md_min  = 1'b0;
    md_hour = 1'b0;
    unique case (fast_mode)
      FM_FAST_MIN:  md_min = 1'b1;
`ifdef ACLK_HOUR_TICK_EN
      FM_FAST_HOUR: md_hour = 1'b1;
`else
      FM_FAST_HOUR: md_min = 1'b1;
`endif
      default: ;
    endcase
  end

  assign normal  = ~md_min & ~md_hour;
  assign ste     = enable & pre_term;
  assign sec_inc = ste & normal;
  assign min_evt = ste & (sec_term | ~normal);
  assign min_inc = min_evt & ~md_hour;

  aclk_mod_counter #(.MODULUS(CLK_PER_SEC)) u_pre (
    .clk      (clk),
    .reset    (reset),
    .clr      (reset_count),
    .inc      (enable),
    .value    (pre_val),
    .terminal (pre_term)
  );

  aclk_mod_counter #(.MODULUS(SEC_PER_MIN)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .clr      (reset_count),
    .inc      (sec_inc),
    .value    (sec_cnt),
    .terminal (sec_term)
  );

`ifdef ACLK_HOUR_TICK_EN
  logic min_term;
  logic hour_evt;
  logic one_hour_q, one_hour_d;

  assign hour_evt   = md_hour ? ste : (min_evt & min_term);
  assign one_hour_d = hour_evt & ~reset_count;
  assign one_hour   = one_hour_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      one_hour_q <= 1'b0;
    end else begin
      one_hour_q <= one_hour_d;
    end
  end
`else
  logic min_term_unused;
  logic min_term;

  assign min_term = min_term_unused;
  assign one_hour = 1'b0;
`endif

  aclk_mod_counter #(.MODULUS(MIN_PER_HOUR)) u_min (
    .clk      (clk),
    .reset    (reset),
    .clr      (reset_count),
    .inc      (min_inc),
    .value    (min_cnt),
`ifdef ACLK_HOUR_TICK_EN
    .terminal (min_term)
`else
    .terminal (min_term_unused)
`endif
  );

  assign one_second_d = ste & ~reset_count;
  assign one_minute_d = min_evt & ~reset_count;
  assign one_second   = one_second_q;
  assign one_minute   = one_minute_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
    end else begin
      one_second_q <= one_second_d;
      one_minute_q <= one_minute_d;
    end
  end

endmodule

// File: doc/aclk_timebase_gen.md
ACLK_TIMEBASE_GEN -- requirements
Module: aclk_timebase_gen

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 256, meaning clk cycles per second tick (legal >= 2).
REQ-002 SHALL have parameter SEC_PER_MIN, default 60, meaning second ticks per minute tick (legal >= 2).
REQ-003 SHALL have parameter MIN_PER_HOUR, default 60, meaning minute ticks per hour tick (legal >= 2).
REQ-004 SHALL have port clk, input, 1, clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port reset_count, input, 1, synchronous clear of all counters and pulses.
REQ-007 SHALL have port enable, input, 1, count enable; low freezes all counters.
REQ-008 SHALL have port fast_mode, input, 2, 00 NORMAL, 01 FAST_MIN, 10 FAST_HOUR, 11 treated as NORMAL.
REQ-009 SHALL have ports one_second, one_minute, one_hour, output, 1 each, single-cycle tick pulses.
REQ-010 SHALL have ports sec_cnt, output, $clog2(SEC_PER_MIN), and min_cnt, output, $clog2(MIN_PER_HOUR), current stage values.

Function
REQ-011 Prescaler SHALL count 0..CLK_PER_SEC-1 when enable=1, wrapping to 0; width $clog2(CLK_PER_SEC).
REQ-012 Second terminal event (STE) SHALL be enable=1 and prescaler=CLK_PER_SEC-1.
REQ-013 one_second SHALL be registered: high exactly one cycle, in the cycle after an STE edge; low otherwise.
REQ-014 NORMAL: sec_cnt SHALL advance on STE, wrap SEC_PER_MIN-1 -> 0; minute event when STE and sec_cnt=SEC_PER_MIN-1.
REQ-015 NORMAL: min_cnt SHALL advance on minute event, wrap MIN_PER_HOUR-1 -> 0; hour event when minute event and min_cnt=MIN_PER_HOUR-1.
REQ-016 FAST_MIN: second stage bypassed; minute event SHALL equal STE; sec_cnt holds; hour event per REQ-015.
REQ-017 FAST_HOUR: minute and hour events SHALL both equal STE; sec_cnt and min_cnt hold.
REQ-018 one_minute and one_hour SHALL be registered from their events, pulse-aligned with one_second on coincident events.
REQ-019 enable=0 SHALL hold all counters and force all pulse outputs low on next edge.
REQ-020 reset_count=1 SHALL, at the next edge, clear all counters and pulses, overriding enable and any terminal event.
REQ-021 fast_mode change SHALL NOT clear counters; new mode applies from the next edge.

Reset
REQ-022 reset SHALL asynchronously clear prescaler, sec_cnt, min_cnt, one_second, one_minute, one_hour to 0.
REQ-023 First one_second after reset release with enable=1 SHALL occur CLK_PER_SEC+1 rising edges after release... i.e. in cycle following edge CLK_PER_SEC.

Configuration
REQ-024 Macro ACLK_HOUR_TICK_EN defined: hour stage, min_cnt wrap and one_hour SHALL be implemented as above.
REQ-025 Macro undefined: min_cnt SHALL wrap freely per REQ-015 but one_hour SHALL be constant 0 and no hour logic built; FAST_HOUR behaves as FAST_MIN.

Structure
REQ-026 Shared package aclk_pkg SHALL hold fast_mode encoding typedef (NORMAL/FAST_MIN/FAST_HOUR) and default constants 256/60/60.
REQ-027 Sub-module aclk_mod_counter (parameter MODULUS; inputs clk, reset, clr, inc; outputs value, terminal) SHALL implement each stage, instantiated three times.

Verification (params CLK_PER_SEC=4, SEC_PER_MIN=3, MIN_PER_HOUR=2, macro defined)
REQ-028 Reset release, enable=1, NORMAL -> one_second high at cycles 4,8,12..; one_minute at 12,24; one_hour at 24,48; all coincident pulses same cycle.
REQ-029 FAST_MIN from reset -> one_minute at 4,8,12 aligned with one_second; one_hour at 8,16; sec_cnt stays 0.
REQ-030 FAST_HOUR -> one_second, one_minute, one_hour all high at cycles 4,8,12.
REQ-031 enable low for 10 cycles at prescaler=2 -> no pulses, counters frozen; next one_second 2 cycles after enable returns.
REQ-032 reset_count asserted same edge as STE with sec_cnt=2 -> no one_second/one_minute pulse, all counters 0, next one_second 4 cycles later.
REQ-033 Macro undefined, FAST_HOUR -> one_hour never high; one_minute at 4,8,12.
